// File: rtl/seq_fcontrol.sv
// Multi-cycle control decoder: one-hot flags plus selector behind a valid/ready handshake.
// Define ILLEGAL_TRAP_EN to add the sticky `illegal` output and selector code 7.
module seq_fcontrol #(
  parameter int unsigned     OP_W       = 5,
  parameter int unsigned     FN_W       = 5,
  parameter int unsigned     MUL_CYCLES = 8,
  parameter int unsigned     DIV_CYCLES = 16,
  parameter int unsigned     CNT_W      = 5,
  parameter logic [OP_W-1:0] OP_RTYPE   = OP_W'(5'b00000),
  parameter logic [FN_W-1:0] FN_MULT    = FN_W'(5'b11000),
  parameter logic [FN_W-1:0] FN_DIV     = FN_W'(5'b11010),
  parameter logic [OP_W-1:0] OP_XORI    = OP_W'(5'b01110),
  parameter logic [OP_W-1:0] OP_BQZT    = OP_W'(5'b00111),
  parameter logic [OP_W-1:0] OP_JAL     = OP_W'(5'b00011)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OP_W-1:0] opcode,
  input  logic [FN_W-1:0] funct,
  input  logic            flush,
  output logic            mult,
  output logic            div,
  output logic            xori,
  output logic            bqzt,
  output logic            jal,
  output logic [2:0]      selector,
  output logic            busy,
  output logic            out_valid
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);

  localparam logic [2:0] SelNone = 3'd0;
  localparam logic [2:0] SelMult = 3'd1;
  localparam logic [2:0] SelDiv  = 3'd2;
  localparam logic [2:0] SelXori = 3'd3;
  localparam logic [2:0] SelBqzt = 3'd4;
  localparam logic [2:0] SelJal  = 3'd5;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [2:0] SelIllegal = 3'd7;
  localparam logic [2:0] SelUnknown = SelIllegal;
`else
  localparam logic [2:0] SelUnknown = SelNone;
`endif

  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);
  // A one-cycle mult/div never leaves idle, so it looks like any single-cycle op.
  localparam bit MulMulti = (MUL_CYCLES > 1);
  localparam bit DivMulti = (DIV_CYCLES > 1);

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  // Flag vector order: {jal, bqzt, xori, div, mult}
  logic [4:0]       flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic [2:0]       dec_sel;
  logic [4:0]       dec_flags;
  logic             accept;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid & in_ready;

  always_comb begin
    dec_sel = SelUnknown;
    if (opcode == OP_RTYPE) begin
      if (funct == FN_MULT) begin
        dec_sel = SelMult;
      end else if (funct == FN_DIV) begin
        dec_sel = SelDiv;
      end
    end else if (opcode == OP_XORI) begin
      dec_sel = SelXori;
    end else if (opcode == OP_BQZT) begin
      dec_sel = SelBqzt;
    end else if (opcode == OP_JAL) begin
      dec_sel = SelJal;
    end
  end

  always_comb begin
    dec_flags = '0;
    case (dec_sel)
      SelMult: dec_flags[0] = 1'b1;
      SelDiv:  dec_flags[1] = 1'b1;
      SelXori: dec_flags[2] = 1'b1;
      SelBqzt: dec_flags[3] = 1'b1;
      SelJal:  dec_flags[4] = 1'b1;
      default: dec_flags = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    flags_d     = flags_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          sel_d   = dec_sel;
          flags_d = dec_flags;
          if ((dec_sel == SelMult) && MulMulti) begin
            state_d = StMul;
            cnt_d   = MulLoad;
          end else if ((dec_sel == SelDiv) && DivMulti) begin
            state_d = StDiv;
            cnt_d   = DivLoad;
          end else begin
            out_valid_d = 1'b1;
          end
        end
      end
      StMul, StDiv: begin
        // Flush beats completion even on the final count.
        if (flush) begin
          state_d = StIdle;
          cnt_d   = '0;
          sel_d   = SelNone;
          flags_d = '0;
        end else if (cnt_q == '0) begin
          state_d     = StIdle;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sel_q       <= SelNone;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  // Sticky until the next accepted instruction decodes as legal.
  always_comb begin
    illegal_d = illegal_q;
    if (accept) begin
      illegal_d = (dec_sel == SelIllegal);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegal = illegal_q;
`endif

  assign mult      = flags_q[0];
  assign div       = flags_q[1];
  assign xori      = flags_q[2];
  assign bqzt      = flags_q[3];
  assign jal       = flags_q[4];
  assign selector  = sel_q;
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_seq_fcontrol.sv
// Scoreboard bench for seq_fcontrol: directed scenarios then random traffic vs a
// transaction-level model (class, latency, sticky illegal).
module tb_seq_fcontrol;

  localparam int MulN = 8;
  localparam int DivN = 16;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] opcode;
  logic [4:0] funct;
  logic       flush;
  logic       mult, div, xori, bqzt, jal;
  logic [2:0] selector;
  logic       busy;
  logic       out_valid;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  seq_fcontrol dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .funct     (funct),
    .flush     (flush),
    .mult      (mult),
    .div       (div),
    .xori      (xori),
    .bqzt      (bqzt),
    .jal       (jal),
    .selector  (selector),
    .busy      (busy),
`ifdef ILLEGAL_TRAP_EN
    .illegal   (illegal),
`endif
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    int sel;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   edge_n = 0;
  bit   chk_en = 1'b0;
  bit   m_busy = 1'b0;
  int   m_done = 0;
  int   m_sel  = 0;
  bit   m_ill  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Instruction class straight from the opcode/funct table.
  function automatic int cls(input logic [4:0] op, input logic [4:0] fn);
    int unk;
`ifdef ILLEGAL_TRAP_EN
    unk = 7;
`else
    unk = 0;
`endif
    if (op == 5'd0) return (fn == 5'd24) ? 1 : (fn == 5'd26) ? 2 : unk;
    if (op == 5'd14) return 3;
    if (op == 5'd7) return 4;
    if (op == 5'd3) return 5;
    return unk;
  endfunction

  function automatic int lat(input int s);
    return (s == 1) ? MulN : (s == 2) ? DivN : 1;
  endfunction

  function automatic logic [4:0] flags_of(input int s);
    return (s >= 1 && s <= 5) ? 5'(1 << (s - 1)) : 5'd0;
  endfunction

  task automatic model_edge(input bit v, input logic [4:0] op, input logic [4:0] fn,
                            input bit fl);
    int s;
    int n;
    if (m_busy) begin
      if (fl) begin
        m_busy = 1'b0;
        m_sel  = 0;
        if (q.size() > 0) void'(q.pop_back());
      end else if (edge_n == m_done) begin
        m_busy = 1'b0;
      end
    end else if (v) begin
      s     = cls(op, fn);
      n     = lat(s);
      m_sel = s;
      m_ill = (s == 7);
      if (n > 1) begin
        m_busy = 1'b1;
        m_done = edge_n + n;
        q.push_back('{edge_n + n, s});
      end else begin
        q.push_back('{edge_n, s});
      end
    end
  endtask

  task automatic step(input bit v, input logic [4:0] op, input logic [4:0] fn, input bit fl);
    in_valid = v;
    opcode   = op;
    funct    = fn;
    flush    = fl;
    @(posedge clk);
    edge_n++;
    model_edge(v, op, fn, fl);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(!m_busy));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("selector", 32'(selector), 32'(m_sel));
      chk("flags", 32'({jal, bqzt, xori, div, mult}), 32'(flags_of(m_sel)));
`ifdef ILLEGAL_TRAP_EN
      chk("illegal", 32'(illegal), 32'(m_ill));
`endif
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("ov_spurious", 32'(out_valid), 32'd0);
        end else begin
          chk("ov_when", 32'(edge_n), 32'(q[0].edge_no));
          chk("ov_sel", 32'(selector), 32'(q[0].sel));
          void'(q.pop_front());
        end
      end else if (q.size() > 0 && q[0].edge_no <= edge_n) begin
        chk("ov_missing", 32'(out_valid), 32'd1);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    bit         hv;
    bit         acc;
    bit         fl;
    logic [4:0] op;
    logic [4:0] fn;
    int         k;

    rst = 1'b1;
    in_valid = 1'b0;
    opcode = '0;
    funct = '0;
    flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_selector", 32'(selector), 32'd0);
    chk("rst_flags", 32'({jal, bqzt, xori, div, mult}), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    chk_en = 1'b1;

    // Back-to-back single-cycle ops.
    step(1'b1, 5'd14, 5'd0, 1'b0);
    step(1'b1, 5'd7, 5'd0, 1'b0);
    step(1'b1, 5'd3, 5'd0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);

    // Mult, with a jal held on in_valid until it is taken.
    step(1'b1, 5'd0, 5'd24, 1'b0);
    for (int i = 0; i < 20; i++) begin
      acc = !m_busy;
      step(1'b1, 5'd3, 5'd0, 1'b0);
      if (acc) break;
    end
    step(1'b0, 5'd0, 5'd0, 1'b0);

    // Div flushed at the fifth edge after accept.
    step(1'b1, 5'd0, 5'd26, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b0, 5'd0, 5'd0, 1'b0);

    // Asynchronous reset in the middle of a div.
    step(1'b1, 5'd0, 5'd26, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 5'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_selector", 32'(selector), 32'd0);
    chk("mid_rst_flags", 32'({jal, bqzt, xori, div, mult}), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ILLEGAL_TRAP_EN
    chk("mid_rst_illegal", 32'(illegal), 32'd0);
`endif
    m_busy = 1'b0;
    m_sel  = 0;
    m_ill  = 1'b0;
    q.delete();
    #1 rst = 1'b0;
    step(1'b1, 5'd3, 5'd0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);

    // Unrecognised opcode, then an xori.
    step(1'b1, 5'd31, 5'd0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 5'd14, 5'd0, 1'b0);
    step(1'b0, 5'd0, 5'd0, 1'b0);

    // Random traffic; a pending request is held until it is accepted.
    hv = 1'b0;
    op = '0;
    fn = '0;
    for (int i = 0; i < 600; i++) begin
      if (!hv) begin
        hv = ($urandom_range(0, 2) != 0);
        k  = $urandom_range(0, 6);
        fn = 5'($urandom);
        case (k)
          0: begin op = 5'd0; fn = 5'd24; end
          1: begin op = 5'd0; fn = 5'd26; end
          2: op = 5'd0;
          3: op = 5'd14;
          4: op = 5'd7;
          5: op = 5'd3;
          default: op = 5'($urandom);
        endcase
      end
      fl  = ($urandom_range(0, 15) == 0);
      acc = hv && !m_busy;
      step(hv, op, fn, fl);
      if (acc) hv = 1'b0;
    end

    for (int i = 0; i < 20; i++) step(1'b0, 5'd0, 5'd0, 1'b0);
    chk("drain", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
